// File: rtl/mem_port_ctrl_pkg.sv
// rtl/mem_port_ctrl_pkg.sv - shared widths, FSM state and transfer-kind types for mem_port_ctrl
package mem_port_ctrl_pkg;

   localparam int M_ADDR_L = 32;
   localparam int M_DATA_L = 32;
   localparam int CNT_W    = 4;

   typedef enum logic [1:0] {
      MPC_IDLE  = 2'd0,
      MPC_ISSUE = 2'd1,
      MPC_WAIT  = 2'd2,
      MPC_ACK   = 2'd3
   } mpc_state_t;

   typedef enum logic {
      KIND_READ  = 1'b0,
      KIND_WRITE = 1'b1
   } kind_t;

endpackage

// File: rtl/mem_port_ctrl_if.sv
// rtl/mem_port_ctrl_if.sv - CPU request/response and SRAM bus bundle for mem_port_ctrl
interface mem_port_ctrl_if import mem_port_ctrl_pkg::*; #(
   parameter int ADDR_W = M_ADDR_L,
   parameter int DATA_W = M_DATA_L
);
   logic              c_re;
   logic [ADDR_W-1:0] read_addr;
   logic              c_we;
   logic [ADDR_W-1:0] write_addr;
   logic [DATA_W-1:0] c_wdata;
   logic [DATA_W-1:0] c_rdata;
   logic              m_rack;
   logic              m_wack;
   logic              busy;
   logic              sram_ce;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;

   // master: CPU plus SRAM side, slave: the controller
   modport master (
      output c_re, read_addr, c_we, write_addr, c_wdata, sram_rdata,
      input  c_rdata, m_rack, m_wack, busy, sram_ce, sram_we, sram_addr, sram_wdata
   );

   modport slave (
      input  c_re, read_addr, c_we, write_addr, c_wdata, sram_rdata,
      output c_rdata, m_rack, m_wack, busy, sram_ce, sram_we, sram_addr, sram_wdata
   );

endinterface

// File: rtl/mem_port_ctrl_rr_arb2.sv
// rtl/mem_port_ctrl_rr_arb2.sv - two-request round-robin arbiter with one-cycle request masks
module rr_arb2 import mem_port_ctrl_pkg::*; (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_rd,
   input  logic       req_wr,
   input  logic       take,
   input  logic       set_mask_rd,
   input  logic       set_mask_wr,
   output logic [1:0] gnt
);
   kind_t last_grant;
   logic  mask_rd;
   logic  mask_wr;
   logic  eff_rd;
   logic  eff_wr;

   // gnt is one-hot {write, read}; on contention the kind not served last wins
   always_comb begin
      eff_rd = req_rd & ~mask_rd;
      eff_wr = req_wr & ~mask_wr;
      gnt    = {eff_wr, eff_rd};
      if (eff_rd && eff_wr) begin
         gnt = (last_grant == KIND_WRITE) ? 2'b01 : 2'b10;
      end
   end

   // A mask is set only during ACK, so it lives for exactly the following IDLE cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant <= KIND_WRITE;
         mask_rd    <= 1'b0;
         mask_wr    <= 1'b0;
      end else begin
         mask_rd <= set_mask_rd;
         mask_wr <= set_mask_wr;
         if (take) begin
            last_grant <= gnt[1] ? KIND_WRITE : KIND_READ;
         end
      end
   end

endmodule

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - arbitrates CPU read/write requests onto one fixed-latency single-port SRAM
module mem_port_ctrl import mem_port_ctrl_pkg::*; #(
   parameter int ADDR_W   = M_ADDR_L,
   parameter int DATA_W   = M_DATA_L,
   parameter int SRAM_LAT = 2
) (
   input logic            clk,
   input logic            rst,
   mem_port_ctrl_if.slave bus
);
   localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(SRAM_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   mpc_state_t        state;
   kind_t             kind;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        gnt;
   logic              take;
   logic [DATA_W-1:0] c_rdata;
   logic [DATA_W-1:0] sram_wdata;
   logic [ADDR_W-1:0] sram_addr;
   logic              m_rack;
   logic              m_wack;
   logic              busy;
   logic              sram_ce;
   logic              sram_we;

   assign take = (state == MPC_IDLE) && (gnt != 2'b00);

   rr_arb2 u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_rd      (bus.c_re),
      .req_wr      (bus.c_we),
      .take        (take),
      .set_mask_rd ((state == MPC_ACK) && (kind == KIND_READ)),
      .set_mask_wr ((state == MPC_ACK) && (kind == KIND_WRITE)),
      .gnt         (gnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= MPC_IDLE;
         kind       <= KIND_READ;
         cnt        <= '0;
         c_rdata    <= '0;
         m_rack     <= 1'b0;
         m_wack     <= 1'b0;
         busy       <= 1'b0;
         sram_ce    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         m_rack <= 1'b0;
         m_wack <= 1'b0;
         case (state)
            // Address and data are captured here; later CPU changes are ignored
            MPC_IDLE: begin
               if (take) begin
                  kind      <= gnt[1] ? KIND_WRITE : KIND_READ;
                  sram_ce   <= 1'b1;
                  sram_we   <= gnt[1];
                  sram_addr <= gnt[1] ? bus.write_addr : bus.read_addr;
                  if (gnt[1]) begin
                     sram_wdata <= bus.c_wdata;
                  end
                  busy  <= 1'b1;
                  state <= MPC_ISSUE;
               end
            end
            MPC_ISSUE: begin
               sram_ce <= 1'b0;
               sram_we <= 1'b0;
               cnt     <= LAT_INIT;
               state   <= MPC_WAIT;
            end
            MPC_WAIT: begin
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  if (kind == KIND_READ) begin
                     c_rdata <= bus.sram_rdata;
                     m_rack  <= 1'b1;
                  end else begin
                     m_wack  <= 1'b1;
                  end
                  state <= MPC_ACK;
               end
            end
            MPC_ACK: begin
               busy  <= 1'b0;
               state <= MPC_IDLE;
            end
            default: state <= MPC_IDLE;
         endcase
      end
   end

   assign bus.c_rdata    = c_rdata;
   assign bus.m_rack     = m_rack;
   assign bus.m_wack     = m_wack;
   assign bus.busy       = busy;
   assign bus.sram_ce    = sram_ce;
   assign bus.sram_we    = sram_we;
   assign bus.sram_addr  = sram_addr;
   assign bus.sram_wdata = sram_wdata;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - directed and randomized checks of mem_port_ctrl against a transaction-level model
module tb_mem_port_ctrl;
   localparam int LAT_A = 2;
   localparam int LAT_B = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   mem_port_ctrl_if #(.ADDR_W(32), .DATA_W(32)) a_if ();
   mem_port_ctrl_if #(.ADDR_W(32), .DATA_W(32)) b_if ();

   mem_port_ctrl #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(LAT_A)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if.slave)
   );

   mem_port_ctrl #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(LAT_B)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int idx(input logic [31:0] addr);
      return int'(addr[9:2]);
   endfunction

   function automatic logic [31:0] init_word(input int i);
      if (i == 64) return 32'hDEAD_BEEF;
      return 32'h5EED_0000 ^ (32'(i) * 32'h0101_0103);
   endfunction

   function automatic logic [31:0] rnd_addr();
      return 32'h300 + 32'(4 * $urandom_range(0, 15));
   endfunction

   // SRAM models: data becomes visible SRAM_LAT-1 edges after the edge that samples ce
   logic [31:0] sram_a [256];
   logic [31:0] q_a = '0;
   int          rem_a = 0;
   bit          init_a = 1'b0;
   always @(posedge clk) begin
      if (!init_a) begin
         for (int i = 0; i < 256; i++) sram_a[i] <= init_word(i);
         init_a <= 1'b1;
      end else if (a_if.sram_ce) begin
         if (a_if.sram_we) sram_a[idx(a_if.sram_addr)] <= a_if.sram_wdata;
         else begin
            q_a   <= sram_a[idx(a_if.sram_addr)];
            rem_a <= LAT_A - 1;
         end
      end else if (rem_a > 0) rem_a <= rem_a - 1;
   end
   assign a_if.sram_rdata = (rem_a == 0) ? q_a : 32'hBAD0_BAD0;

   logic [31:0] sram_b [256];
   logic [31:0] q_b = '0;
   int          rem_b = 0;
   bit          init_b = 1'b0;
   always @(posedge clk) begin
      if (!init_b) begin
         for (int i = 0; i < 256; i++) sram_b[i] <= init_word(i);
         init_b <= 1'b1;
      end else if (b_if.sram_ce) begin
         if (b_if.sram_we) sram_b[idx(b_if.sram_addr)] <= b_if.sram_wdata;
         else begin
            q_b   <= sram_b[idx(b_if.sram_addr)];
            rem_b <= LAT_B - 1;
         end
      end else if (rem_b > 0) rem_b <= rem_b - 1;
   end
   assign b_if.sram_rdata = (rem_b == 0) ? q_b : 32'hBAD0_BAD0;

   // Transaction-level reference for dut_a: a grant in cycle g issues in g+1, acks in g+2+LAT,
   // frees the port from g+3+LAT and masks the same kind in cycle g+3+LAT.
   logic [31:0] mem_ref [256];
   bit          ref_init = 1'b0;
   bit          t_valid = 1'b0;
   bit          t_wr = 1'b0;
   logic [31:0] t_addr = '0;
   logic [31:0] t_data = '0;
   logic [31:0] last_rd = '0;
   int          t_grant = 0;
   int          t_ack = 0;
   int          busy_until = -1;
   int          mask_rd_at = -1;
   int          mask_wr_at = -1;
   bit          last_wr = 1'b1;
   bit          er, ew, gw, exp_rack, exp_wack, exp_ce;

   always @(negedge clk) begin
      if (!ref_init) begin
         for (int i = 0; i < 256; i++) mem_ref[i] = init_word(i);
         ref_init = 1'b1;
      end
      if (!rst) begin
         t_valid = 1'b0; busy_until = -1; mask_rd_at = -1; mask_wr_at = -1;
         last_wr = 1'b1; last_rd = '0;
         chk("rst_rdata", a_if.c_rdata, 0);
         chk("rst_ctl", {a_if.m_rack, a_if.m_wack, a_if.busy, a_if.sram_ce, a_if.sram_we}, 0);
         chk("rst_sram", {a_if.sram_addr, a_if.sram_wdata}, 0);
      end else begin
         exp_rack = t_valid && !t_wr && (cyc == t_ack);
         exp_wack = t_valid &&  t_wr && (cyc == t_ack);
         exp_ce   = t_valid && (cyc == t_grant + 1);
         if (exp_rack) last_rd = t_data;
         chk("ack", {a_if.m_wack, a_if.m_rack}, {exp_wack, exp_rack});
         chk("busy", a_if.busy, t_valid && (cyc > t_grant));
         chk("sram_ce", a_if.sram_ce, exp_ce);
         chk("rdata", a_if.c_rdata, last_rd);
         if (exp_ce) begin
            chk("sram_we", a_if.sram_we, t_wr);
            chk("sram_addr", a_if.sram_addr, t_addr);
            if (t_wr) chk("sram_wdata", a_if.sram_wdata, t_data);
         end
         if (t_valid && cyc == t_ack) t_valid = 1'b0;
         if (!t_valid && cyc > busy_until) begin
            er = a_if.c_re && (cyc != mask_rd_at);
            ew = a_if.c_we && (cyc != mask_wr_at);
            if (er || ew) begin
               gw = (er && ew) ? !last_wr : ew;
               last_wr = gw; t_valid = 1'b1; t_wr = gw;
               t_grant = cyc; t_ack = cyc + 2 + LAT_A; busy_until = t_ack;
               if (gw) begin
                  t_addr = a_if.write_addr; t_data = a_if.c_wdata;
                  mem_ref[idx(t_addr)] = t_data; mask_wr_at = t_ack + 1;
               end else begin
                  t_addr = a_if.read_addr; t_data = mem_ref[idx(t_addr)];
                  mask_rd_at = t_ack + 1;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic wait_ack(input bit sel, input int base, output int off, output logic [1:0] k);
      off = -1;
      k = 2'b00;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         k = sel ? {b_if.m_wack, b_if.m_rack} : {a_if.m_wack, a_if.m_rack};
         if (k != 2'b00) begin
            off = cyc - base;
            return;
         end
      end
   endtask

   initial begin
      int         off;
      int         base;
      int         noack;
      logic [1:0] k;
      bit         sr, sw;

      a_if.c_re = 1'b0; a_if.read_addr = '0; a_if.c_we = 1'b0; a_if.write_addr = '0; a_if.c_wdata = '0;
      b_if.c_re = 1'b0; b_if.read_addr = '0; b_if.c_we = 1'b0; b_if.write_addr = '0; b_if.c_wdata = '0;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      idle(2);

      // single read
      a_if.c_re = 1'b1; a_if.read_addr = 32'h100; base = cyc;
      wait_ack(1'b0, base, off, k);
      chk("rd_lat", off, 4);
      chk("rd_kind", k, 2'b01);
      chk("rd_data", a_if.c_rdata, 32'hDEAD_BEEF);
      step(); a_if.c_re = 1'b0; idle(3);

      // single write
      a_if.c_we = 1'b1; a_if.write_addr = 32'h200; a_if.c_wdata = 32'h1234_5678; base = cyc;
      wait_ack(1'b0, base, off, k);
      chk("wr_lat", off, 4);
      chk("wr_kind", k, 2'b10);
      chk("wr_rdata_kept", a_if.c_rdata, 32'hDEAD_BEEF);
      step(); a_if.c_we = 1'b0; idle(3);
      chk("wr_sram_word", sram_a[128], 32'h1234_5678);

      // contention, two rounds
      for (int r = 0; r < 2; r++) begin
         a_if.c_re = 1'b1; a_if.read_addr = 32'h100;
         a_if.c_we = 1'b1; a_if.write_addr = 32'h204; a_if.c_wdata = $urandom; base = cyc;
         wait_ack(1'b0, base, off, k);
         chk("cont_first_kind", k, 2'b01);
         chk("cont_first_lat", off, 4);
         step(); a_if.c_re = 1'b0;
         wait_ack(1'b0, base, off, k);
         chk("cont_second_kind", k, 2'b10);
         chk("cont_second_lat", off, 9);
         step(); a_if.c_we = 1'b0; idle(3);
      end

      // request held through the ack is masked for one IDLE cycle
      a_if.c_re = 1'b1; a_if.read_addr = 32'h100; base = cyc;
      wait_ack(1'b0, base, off, k);
      chk("held_first_lat", off, 4);
      wait_ack(1'b0, base, off, k);
      chk("held_second_lat", off, 10);
      step(); a_if.c_re = 1'b0; idle(3);

      // asynchronous reset during WAIT
      a_if.c_re = 1'b1; a_if.read_addr = 32'h108;
      step(); step(); #1 rst = 1'b0; #1;
      chk("rst_mid_rdata", a_if.c_rdata, 0);
      chk("rst_mid_ctl", {a_if.m_rack, a_if.m_wack, a_if.busy, a_if.sram_ce, a_if.sram_we}, 0);
      noack = 0;
      repeat (3) begin
         @(negedge clk);
         noack += int'(a_if.m_rack | a_if.m_wack);
      end
      chk("rst_mid_noack", noack, 0);
      step(); rst = 1'b1; base = cyc;
      wait_ack(1'b0, base, off, k);
      chk("post_rst_lat", off, 4);
      chk("post_rst_data", a_if.c_rdata, init_word(66));
      step(); a_if.c_re = 1'b0; idle(3);

      // randomized CPU behaviour, checked cycle by cycle by the reference model
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         sr = a_if.m_rack;
         sw = a_if.m_wack;
         step();
         if (a_if.c_re) begin
            if (sr && $urandom_range(0, 3) != 0) a_if.c_re = 1'b0;
            else if ($urandom_range(0, 15) == 0) a_if.c_re = 1'b0;
            else if ($urandom_range(0, 7) == 0) a_if.read_addr = rnd_addr();
         end else if ($urandom_range(0, 3) == 0) begin
            a_if.c_re = 1'b1; a_if.read_addr = rnd_addr();
         end
         if (a_if.c_we) begin
            if (sw && $urandom_range(0, 3) != 0) a_if.c_we = 1'b0;
            else if ($urandom_range(0, 15) == 0) a_if.c_we = 1'b0;
            else if ($urandom_range(0, 7) == 0) a_if.c_wdata = $urandom;
         end else if ($urandom_range(0, 3) == 0) begin
            a_if.c_we = 1'b1; a_if.write_addr = rnd_addr(); a_if.c_wdata = $urandom;
         end
      end
      a_if.c_re = 1'b0; a_if.c_we = 1'b0;
      idle(10);

      // SRAM_LAT=1 build
      b_if.c_re = 1'b1; b_if.read_addr = 32'h40; base = cyc;
      wait_ack(1'b1, base, off, k);
      chk("lat1_lat", off, 3);
      chk("lat1_kind", k, 2'b01);
      chk("lat1_data", b_if.c_rdata, init_word(16));
      step(); b_if.c_re = 1'b0; idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
